// File: rtl/game_timer_pkg.sv
// Shared definitions for the game timer controller: FSM state encoding and default time width.
package game_timer_pkg;

  localparam int TIME_W = 27;

  typedef enum logic [1:0] {
    ST_SETUP   = 2'd0,
    ST_RUN     = 2'd1,
    ST_PAUSE   = 2'd2,
    ST_EXPIRED = 2'd3
  } state_t;

endpackage

// File: rtl/timer_warn_blink.sv
// Warning blinker: o_warn toggles every BLINK_DIV enabled cycles; dropping i_en clears counter and output.
module timer_warn_blink #(
  parameter int BLINK_DIV = 25000000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  output logic o_warn
);

  localparam int CNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_DIV - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_warn;

  always_ff @(posedge clk) begin
    if (rst || !i_en) begin
      r_cnt  <= '0;
      r_warn <= 1'b0;
    end else if (r_cnt == CNT_LAST) begin
      r_cnt  <= '0;
      r_warn <= ~r_warn;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_warn = r_warn;

endmodule

// File: rtl/game_timer_ctrl.sv
// Game timer controller: setup/run/pause/expired FSM driving a countdown datapath.
// Optional blinking warning is built only when TIMER_CTRL_WARN_EN is defined.
module game_timer_ctrl #(
  parameter int TIME_W       = game_timer_pkg::TIME_W,
  parameter int DEFAULT_TIME = 60,
  parameter int STEP         = 10,
  parameter int MAX_TIME     = 99999999,
  parameter int WARN_TIME    = 10,
  parameter int BLINK_DIV    = 25000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              btn_start,
  input  logic              btn_pause,
  input  logic              btn_up,
  input  logic              btn_down,
  input  logic [TIME_W-1:0] last_time,
  output logic [TIME_W-1:0] start_time,
  output logic              setting_change,
  output logic              clock_go,
  output logic [1:0]        state,
  output logic              time_up,
  output logic              warn,
  output logic [7:0]        round_cnt
);

  import game_timer_pkg::*;

  localparam logic [TIME_W:0]   STEP_X    = (TIME_W+1)'(STEP);
  localparam logic [TIME_W:0]   MAX_X     = (TIME_W+1)'(MAX_TIME);
  localparam logic [TIME_W-1:0] STEP_T    = TIME_W'(STEP);
  localparam logic [TIME_W-1:0] MAX_T     = TIME_W'(MAX_TIME);
  localparam logic [TIME_W-1:0] DEFAULT_T = TIME_W'(DEFAULT_TIME);

  state_t            r_state, w_state_nxt;
  logic [TIME_W-1:0] r_start_time, w_start_nxt;
  logic [TIME_W:0]   w_sum, w_diff;
  logic              w_expire;
  logic              r_time_up;
  logic [7:0]        r_round_cnt;

  assign w_sum    = {1'b0, r_start_time} + STEP_X;
  assign w_diff   = {1'b0, r_start_time} - STEP_X;
  assign w_expire = (r_state == ST_RUN) && (last_time == '0);

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_SETUP;
    else     r_state <= w_state_nxt;
  end

  // A start press in SETUP masks up/down even when the reload handshake is not yet complete.
  always_comb begin
    w_state_nxt = r_state;
    w_start_nxt = r_start_time;
    case (r_state)
      ST_SETUP: begin
        if (btn_start) begin
          if (last_time == r_start_time) w_state_nxt = ST_RUN;
        end else if (btn_up) begin
          w_start_nxt = (w_sum > MAX_X) ? MAX_T : w_sum[TIME_W-1:0];
        end else if (btn_down) begin
          w_start_nxt = (w_diff[TIME_W] || (w_diff < STEP_X)) ? STEP_T : w_diff[TIME_W-1:0];
        end
      end
      ST_RUN: begin
        if (w_expire)       w_state_nxt = ST_EXPIRED;
        else if (btn_pause) w_state_nxt = ST_PAUSE;
      end
      ST_PAUSE: begin
        if (btn_start)      w_state_nxt = ST_SETUP;
        else if (btn_pause) w_state_nxt = ST_RUN;
      end
      ST_EXPIRED: begin
        if (btn_start) w_state_nxt = ST_SETUP;
      end
      default: w_state_nxt = ST_SETUP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_start_time <= DEFAULT_T;
      r_time_up    <= 1'b0;
      r_round_cnt  <= '0;
    end else begin
      r_start_time <= w_start_nxt;
      r_time_up    <= w_expire;
      if (w_expire && (r_round_cnt != 8'hFF)) r_round_cnt <= r_round_cnt + 8'd1;
    end
  end

  assign start_time     = r_start_time;
  assign setting_change = (r_state == ST_SETUP);
  assign clock_go       = (r_state == ST_RUN);
  assign state          = r_state;
  assign time_up        = r_time_up;
  assign round_cnt      = r_round_cnt;

`ifdef TIMER_CTRL_WARN_EN
  localparam logic [TIME_W-1:0] WARN_T = TIME_W'(WARN_TIME);
  logic w_warn_en;

  assign w_warn_en = (r_state == ST_RUN) && (last_time != '0) && (last_time <= WARN_T);

  timer_warn_blink #(.BLINK_DIV(BLINK_DIV)) u_warn_blink (
    .clk    (clk),
    .rst    (rst),
    .i_en   (w_warn_en),
    .o_warn (warn)
  );
`else
  // Warning parameters are meaningless without the blinker; fold them into a sink.
  logic w_unused_cfg;
  assign w_unused_cfg = ^{WARN_TIME, BLINK_DIV};
  assign warn         = 1'b0;
`endif

endmodule

// File: tb/tb_game_timer_ctrl.sv
// Self-checking bench for game_timer_ctrl with a behavioural countdown datapath model.
module tb_game_timer_ctrl;

  localparam int TIME_W = 27;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              btn_start = 1'b0, btn_pause = 1'b0, btn_up = 1'b0, btn_down = 1'b0;
  logic [TIME_W-1:0] last_time = '0;
  logic [TIME_W-1:0] start_time;
  logic              setting_change, clock_go, time_up, warn;
  logic [1:0]        state;
  logic [7:0]        round_cnt;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic              ovr = 1'b0;
  logic [TIME_W-1:0] ovr_val = '0;

  game_timer_ctrl #(
    .TIME_W(TIME_W), .DEFAULT_TIME(60), .STEP(10), .MAX_TIME(100),
    .WARN_TIME(10), .BLINK_DIV(4)
  ) dut (
    .clk(clk), .rst(rst), .btn_start(btn_start), .btn_pause(btn_pause),
    .btn_up(btn_up), .btn_down(btn_down), .last_time(last_time),
    .start_time(start_time), .setting_change(setting_change), .clock_go(clock_go),
    .state(state), .time_up(time_up), .warn(warn), .round_cnt(round_cnt)
  );

  always #5 clk = ~clk;

  // Countdown datapath: reloads while setting_change, counts while clock_go; ovr pins the value.
  always @(posedge clk) begin
    if (ovr)                                 last_time <= ovr_val;
    else if (setting_change === 1'b1)        last_time <= start_time;
    else if (clock_go === 1'b1 && last_time != 0) last_time <= last_time - 1'b1;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic s, input logic p, input logic u, input logic d);
    btn_start = s; btn_pause = p; btn_up = u; btn_down = d;
    @(negedge clk);
    btn_start = 1'b0; btn_pause = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
  endtask

  task automatic do_reset();
    ovr = 1'b0;
    rst = 1'b1;
    step(2);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; btn_start = 1'b1; btn_pause = 1'b1;
    step(1);
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", state); end
    checks++; if (start_time !== 27'd60) begin errors++; $display("FAIL reset_start_time: got %0d want 60", start_time); end
    checks++; if (setting_change !== 1'b1 || clock_go !== 1'b0) begin errors++;
      $display("FAIL reset_decodes: sc=%b go=%b want sc=1 go=0", setting_change, clock_go); end
    checks++; if (time_up !== 1'b0 || warn !== 1'b0 || round_cnt !== 8'd0) begin errors++;
      $display("FAIL reset_outputs: time_up=%b warn=%b round=%0d want 0 0 0", time_up, warn, round_cnt); end
    btn_start = 1'b0; btn_pause = 1'b0;
    step(1);
    rst = 1'b0;
  endtask

  task automatic test_adjust();
    logic [31:0] model, got_exp;
    do_reset();
    model = 60;
    for (int i = 0; i < 5; i++) begin
      press(1'b0, 1'b0, 1'b1, 1'b0);
      model = (model + 10 > 100) ? 100 : model + 10;
      exp_q.push_back(model);
      got_exp = exp_q.pop_front();
      checks++; if (start_time !== got_exp[TIME_W-1:0]) begin errors++;
        $display("FAIL adjust_up[%0d]: start_time=%0d want %0d", i, start_time, got_exp); end
    end
    for (int i = 0; i < 12; i++) begin
      press(1'b0, 1'b0, 1'b0, 1'b1);
      model = (model < 20) ? 10 : model - 10;
      exp_q.push_back(model);
      got_exp = exp_q.pop_front();
      checks++; if (start_time !== got_exp[TIME_W-1:0]) begin errors++;
        $display("FAIL adjust_down[%0d]: start_time=%0d want %0d", i, start_time, got_exp); end
    end
    // up and down together: up outranks down
    press(1'b0, 1'b0, 1'b1, 1'b1);
    checks++; if (start_time !== 27'd20) begin errors++;
      $display("FAIL adjust_up_over_down: start_time=%0d want 20", start_time); end
  endtask

  task automatic test_handshake();
    do_reset();
    ovr = 1'b1; ovr_val = 27'd50;
    step(2);
    press(1'b1, 1'b0, 1'b0, 1'b0);
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL handshake_blocked: state=%0d want 0", state); end
    ovr = 1'b0;
    step(2);
    press(1'b1, 1'b0, 1'b0, 1'b0);
    checks++; if (state !== 2'd1 || clock_go !== 1'b1 || setting_change !== 1'b0) begin errors++;
      $display("FAIL handshake_run: state=%0d go=%b sc=%b want 1 1 0", state, clock_go, setting_change); end
  endtask

  task automatic test_expiry();
    int n;
    logic [31:0] e;
    do_reset();
    step(1);
    press(1'b1, 1'b0, 1'b0, 1'b0);
    exp_q.push_back(32'd1);
    n = 0;
    while (last_time != 0 && n < 200) begin @(negedge clk); n++; end
    checks++; if (n >= 200) begin errors++; $display("FAIL expiry_timeout: last_time=%0d want 0 within 200 cycles", last_time); end
    checks++; if (state !== 2'd1 || time_up !== 1'b0) begin errors++;
      $display("FAIL expiry_pre: state=%0d time_up=%b want 1 0", state, time_up); end
    step(1);
    e = exp_q.pop_front();
    checks++; if (state !== 2'd3 || time_up !== 1'b1 || round_cnt !== e[7:0]) begin errors++;
      $display("FAIL expiry_edge: state=%0d time_up=%b round=%0d want 3 1 %0d", state, time_up, round_cnt, e); end
    step(1);
    checks++; if (time_up !== 1'b0 || state !== 2'd3) begin errors++;
      $display("FAIL expiry_pulse_width: time_up=%b state=%0d want 0 3", time_up, state); end
    press(1'b0, 1'b1, 1'b1, 1'b0);
    checks++; if (state !== 2'd3 || start_time !== 27'd60) begin errors++;
      $display("FAIL expiry_ignore: state=%0d start_time=%0d want 3 60", state, start_time); end
    press(1'b1, 1'b0, 1'b0, 1'b0);
    checks++; if (state !== 2'd0 || start_time !== 27'd60 || round_cnt !== 8'd1) begin errors++;
      $display("FAIL expiry_to_setup: state=%0d start_time=%0d round=%0d want 0 60 1", state, start_time, round_cnt); end
  endtask

  task automatic test_pause();
    logic [TIME_W-1:0] held;
    logic [31:0] e;
    do_reset();
    step(1);
    press(1'b1, 1'b0, 1'b0, 1'b0);
    press(1'b0, 1'b1, 1'b0, 1'b0);
    checks++; if (state !== 2'd2 || clock_go !== 1'b0) begin errors++;
      $display("FAIL pause_enter: state=%0d go=%b want 2 0", state, clock_go); end
    step(1);
    held = last_time;
    step(3);
    checks++; if (last_time !== held) begin errors++; $display("FAIL pause_hold: last_time=%0d want %0d", last_time, held); end
    press(1'b0, 1'b1, 1'b0, 1'b0);
    checks++; if (state !== 2'd1 || clock_go !== 1'b1) begin errors++;
      $display("FAIL pause_resume: state=%0d go=%b want 1 1", state, clock_go); end
    press(1'b0, 1'b1, 1'b0, 1'b0);
    press(1'b1, 1'b0, 1'b0, 1'b0);
    checks++; if (state !== 2'd0 || setting_change !== 1'b1) begin errors++;
      $display("FAIL pause_abort: state=%0d sc=%b want 0 1", state, setting_change); end
    step(2);
    press(1'b1, 1'b0, 1'b1, 1'b0);
    checks++; if (state !== 2'd1 || start_time !== 27'd60) begin errors++;
      $display("FAIL start_over_up: state=%0d start_time=%0d want 1 60", state, start_time); end
    press(1'b0, 1'b0, 1'b1, 1'b0);
    checks++; if (start_time !== 27'd60 || state !== 2'd1) begin errors++;
      $display("FAIL up_in_run: start_time=%0d state=%0d want 60 1", start_time, state); end
    ovr = 1'b1; ovr_val = '0;
    exp_q.push_back(32'd1);
    step(1);
    press(1'b0, 1'b1, 1'b0, 1'b0);
    e = exp_q.pop_front();
    checks++; if (state !== 2'd3 || time_up !== 1'b1 || round_cnt !== e[7:0]) begin errors++;
      $display("FAIL expiry_beats_pause: state=%0d time_up=%b round=%0d want 3 1 %0d", state, time_up, round_cnt, e); end
    ovr = 1'b0;
  endtask

  task automatic test_warn();
    int last_change, n_change, gap_err;
    logic prev;
    do_reset();
    step(1);
    press(1'b1, 1'b0, 1'b0, 1'b0);
    ovr = 1'b1; ovr_val = 27'd10;
    prev = 1'b0; last_change = 0; n_change = 0; gap_err = 0;
    for (int i = 1; i <= 24; i++) begin
      @(negedge clk);
`ifdef TIMER_CTRL_WARN_EN
      if (i == 1) begin
        checks++; if (warn !== 1'b0) begin errors++; $display("FAIL warn_initial: warn=%b want 0", warn); end
      end
      if (warn !== prev) begin
        if (n_change > 0) begin
          checks++; if (i - last_change != 4) begin errors++;
            $display("FAIL warn_period: toggle gap=%0d want 4", i - last_change); end
        end
        n_change++; last_change = i; prev = warn;
      end
`else
      checks++; if (warn !== 1'b0) begin errors++; $display("FAIL warn_disabled: warn=%b want 0 at cycle %0d", warn, i); end
`endif
    end
`ifdef TIMER_CTRL_WARN_EN
    checks++; if (n_change < 4) begin errors++; $display("FAIL warn_toggles: count=%0d want >=4", n_change); end
`endif
    ovr_val = 27'd11;
    step(2);
    checks++; if (warn !== 1'b0) begin errors++; $display("FAIL warn_above_thresh: warn=%b want 0", warn); end
    ovr_val = 27'd10;
    step(5);
`ifdef TIMER_CTRL_WARN_EN
    checks++; if (warn !== 1'b1) begin errors++; $display("FAIL warn_rearm: warn=%b want 1", warn); end
`endif
    press(1'b0, 1'b1, 1'b0, 1'b0);
    step(1);
    checks++; if (warn !== 1'b0 || state !== 2'd2) begin errors++;
      $display("FAIL warn_pause: warn=%b state=%0d want 0 2", warn, state); end
    ovr = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    do_reset();
    step(1);
    press(1'b1, 1'b0, 1'b0, 1'b0);
    ovr = 1'b1; ovr_val = '0;
    step(2);
    checks++; if (round_cnt !== 8'd1 || state !== 2'd3) begin errors++;
      $display("FAIL midrun_pre_expiry: round=%0d state=%0d want 1 3", round_cnt, state); end
    ovr = 1'b0;
    press(1'b1, 1'b0, 1'b0, 1'b0);
    press(1'b0, 1'b0, 1'b1, 1'b0);
    step(2);
    press(1'b1, 1'b0, 1'b0, 1'b0);
    step(3);
    checks++; if (state !== 2'd1 || start_time !== 27'd70) begin errors++;
      $display("FAIL midrun_running: state=%0d start_time=%0d want 1 70", state, start_time); end
    rst = 1'b1; btn_pause = 1'b1;
    step(1);
    checks++; if (state !== 2'd0 || start_time !== 27'd60 || round_cnt !== 8'd0) begin errors++;
      $display("FAIL midrun_reset: state=%0d start_time=%0d round=%0d want 0 60 0", state, start_time, round_cnt); end
    checks++; if (clock_go !== 1'b0 || setting_change !== 1'b1 || time_up !== 1'b0) begin errors++;
      $display("FAIL midrun_reset_decodes: go=%b sc=%b time_up=%b want 0 1 0", clock_go, setting_change, time_up); end
    rst = 1'b0; btn_pause = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_adjust();
    test_handshake();
    test_expiry();
    test_pause();
    test_warn();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/game_timer_ctrl.md
GAME_TIMER_CTRL -- requirements
Module: game_timer_ctrl

Interface
REQ-001 Parameter TIME_W, default 27, SHALL set the width of every time value.
REQ-002 Parameter DEFAULT_TIME, default 60, SHALL set the start_time value after reset.
REQ-003 Parameter STEP, default 10, SHALL set the increment/decrement per adjust button pulse.
REQ-004 Parameter MAX_TIME, default 99999999, SHALL set the upper saturation bound of start_time.
REQ-005 Parameter WARN_TIME, default 10, SHALL set the remaining-time threshold for the warning.
REQ-006 Parameter BLINK_DIV, default 25000000, SHALL set the number of clk cycles per warn half-period.
REQ-007 Ports SHALL be:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- btn_start  in  1  one-cycle debounced pulse.
- btn_pause  in  1  one-cycle pulse.
- btn_up  in  1  one-cycle pulse.
- btn_down  in  1  one-cycle pulse.
- last_time  in  TIME_W  remaining time from the countdown datapath.
- start_time  out  TIME_W  preset to the countdown datapath.
- setting_change  out  1  level; datapath reloads start_time while high.
- clock_go  out  1  level; datapath counts down while high.
- state  out  2  current FSM state.
- time_up  out  1  one-cycle expiry pulse.
- warn  out  1  blinking warning.
- round_cnt  out  8  completed-round count.

Function
REQ-008 FSM states SHALL be SETUP=0, RUN=1, PAUSE=2, EXPIRED=3.
REQ-009 setting_change SHALL equal (state==SETUP) and clock_go SHALL equal (state==RUN), both registered-state decodes with no extra latency.
REQ-010 In SETUP, btn_up SHALL add STEP to start_time, saturating at MAX_TIME.
REQ-011 In SETUP, btn_down SHALL subtract STEP from start_time, saturating at STEP (never 0).
- Arithmetic SHALL use TIME_W+1 bits before clamping.
REQ-012 In SETUP, btn_start SHALL move to RUN only when last_time==start_time (reload handshake complete); otherwise the pulse is ignored and not queued.
REQ-013 In RUN, btn_pause SHALL move to PAUSE, and last_time==0 SHALL move to EXPIRED on the next clk edge.
REQ-014 In PAUSE, btn_pause SHALL return to RUN, and btn_start SHALL abort to SETUP.
REQ-015 In EXPIRED, btn_start SHALL move to SETUP with start_time unchanged; all other buttons are ignored.
REQ-016 Button priority when several buttons pulse in the same cycle SHALL be start > pause > up > down; only the highest-priority button valid in the current state acts.
REQ-017 btn_up/btn_down outside SETUP SHALL be ignored.
REQ-018 time_up SHALL pulse for exactly one cycle on the RUN->EXPIRED transition.
REQ-019 round_cnt SHALL increment on the RUN->EXPIRED transition, saturating at 255.
REQ-020 If last_time==0 and btn_pause coincide in RUN, expiry SHALL win.

Reset
REQ-021 On rst, outputs SHALL take these values on the next clk edge:
- state=SETUP, start_time=DEFAULT_TIME, setting_change=1, clock_go=0, time_up=0, warn=0, round_cnt=0, blink counter=0.
REQ-022 rst SHALL override all buttons and any in-progress state, including mid-RUN.

Configuration
REQ-023 With TIMER_CTRL_WARN_EN defined, warn SHALL toggle every BLINK_DIV cycles while state==RUN and 0<last_time<=WARN_TIME, and SHALL be 0 otherwise, with the counter cleared whenever that condition is false.
REQ-024 Without TIMER_CTRL_WARN_EN, warn SHALL be constant 0 and no blink counter SHALL exist.

Structure
REQ-025 Package game_timer_pkg SHALL hold the state encoding typedef and the TIME_W constant.
REQ-026 The blink divider SHALL be sub-module timer_warn_blink, instantiated only under TIMER_CTRL_WARN_EN.

Verification
REQ-027 The bench SHALL run with STEP=10, MAX_TIME=100, DEFAULT_TIME=60, WARN_TIME=10, BLINK_DIV=4, with last_time driven by a behavioural countdown model.
REQ-028 Adjust scenario: reset, then 5x btn_up -> start_time=100 (saturated); 12x btn_down -> start_time=10 (floor).
REQ-029 Handshake scenario: btn_start while last_time=50 and start_time=60 -> state stays SETUP; model reloads to 60, btn_start -> state=RUN, clock_go=1.
REQ-030 Expiry scenario: RUN, last_time reaches 0 -> state=EXPIRED next cycle, time_up high one cycle, round_cnt=1; btn_start -> SETUP, start_time=60.
REQ-031 Pause scenario: btn_pause in RUN -> clock_go=0; btn_start in PAUSE -> SETUP; btn_start+btn_up same cycle in SETUP -> only start acts.
REQ-032 Warning scenario (macro on): RUN with last_time=10 -> warn toggles every 4 cycles; last_time=11 or PAUSE -> warn=0; macro off -> warn=0 always.
REQ-033 Reset scenario: rst asserted mid-RUN -> SETUP, start_time=60, round_cnt=0 next edge.
